// File: rtl/com_stream_ctrl.sv
// com_stream_ctrl: host load -> core run -> host dump sequencer over one memory port
module com_stream_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LOAD_BASE  = 0,
   parameter int DUMP_BASE  = 0,
   parameter int DUMP_LEN   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  data_write_start,
   input  logic                  data_write_done,
   input  logic [DATA_WIDTH-1:0] com_data_in,
   input  logic                  com_valid_in,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  cores_start,
   input  logic                  cores_done,
   output logic [DATA_WIDTH-1:0] com_data_out,
   output logic                  com_valid_out,
   input  logic                  com_ready_in,
   output logic                  output_write_start,
   output logic                  output_write_done,
   output logic                  load_overflow
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LEN = CW'(DUMP_LEN);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} state_t;
   state_t state, state_n;

   logic [CW-1:0]         load_ptr, rd_cnt, xf_cnt;
   logic                  run_seen, rd_pend, issue, xfer, full_ptr;
   logic [1:0]            occ, occ_left;
   logic [DATA_WIDTH-1:0] buf1;

   // The load pointer carries one extra bit so "past the top address" is visible and never wraps.
   assign full_ptr = load_ptr[ADDR_WIDTH];
   assign xfer = com_valid_out & com_ready_in;
   assign occ_left = occ - {1'b0, xfer};
   // A read is only issued when the two-entry output buffer is sure to have room when its data lands.
   assign issue = (state == DUMP) && (rd_cnt < LEN) &&
                  ({1'b0, occ} + {2'b0, rd_pend} <= 3'd1 + {2'b0, xfer});
   assign com_valid_out = occ != 2'd0;

   // Next state and per-state combinational outputs
   always_comb begin
      state_n = state;
      mem_addr = '0;
      mem_wdata = '0;
      mem_we = 1'b0;
      cores_start = 1'b0;
      output_write_start = 1'b0;
      output_write_done = 1'b0;
      case (state)
         IDLE: if (data_write_start) state_n = LOAD;
         LOAD: begin
            mem_addr = load_ptr[ADDR_WIDTH-1:0];
            mem_wdata = com_data_in;
            mem_we = com_valid_in & ~full_ptr;
            if (data_write_done) state_n = RUN;
         end
         RUN: begin
            cores_start = ~run_seen;
            if (run_seen && cores_done) state_n = DUMP;
         end
         DUMP: begin
            mem_addr = ADDR_WIDTH'(DUMP_BASE) + rd_cnt[ADDR_WIDTH-1:0];
            output_write_start = 1'b1;
            output_write_done = (LEN == '0) || (xfer && xf_cnt + ONE == LEN);
            if (output_write_done) state_n = DONE;
         end
         DONE: if (!data_write_start) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;

   // Load pointer, sticky overflow flag, first-RUN-cycle tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_ptr <= '0;
         load_overflow <= 1'b0;
         run_seen <= 1'b0;
      end else begin
         if (state == IDLE) load_ptr <= CW'(LOAD_BASE);
         else if (state == LOAD && com_valid_in && !full_ptr) load_ptr <= load_ptr + ONE;
         if (state == LOAD && com_valid_in && full_ptr) load_overflow <= 1'b1;
         run_seen <= state == RUN;
      end
   end

   // Dump reads, in-flight read marker and two-entry output buffer (head drives com_data_out)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= '0;
         xf_cnt <= '0;
         rd_pend <= 1'b0;
         occ <= 2'd0;
         com_data_out <= '0;
         buf1 <= '0;
      end else begin
         rd_pend <= issue;
         rd_cnt <= (state == DUMP) ? rd_cnt + CW'(issue) : '0;
         xf_cnt <= (state == DUMP) ? xf_cnt + CW'(xfer) : '0;
         occ <= occ_left + {1'b0, rd_pend};
         if (xfer) com_data_out <= buf1;
         if (rd_pend && occ_left == 2'd0) com_data_out <= mem_rdata;
         if (rd_pend && occ_left == 2'd1) buf1 <= mem_rdata;
      end
   end
endmodule

// File: tb/tb_com_stream_ctrl.sv
// tb_com_stream_ctrl: randomized load/run/dump sessions on four configurations against a memory-level model
module tb_com_stream_ctrl;
   localparam int AWS [4] = '{8, 2, 3, 3};
   localparam int LBS [4] = '{0, 0, 2, 0};
   localparam int DBS [4] = '{0, 0, 6, 0};
   localparam int DLS [4] = '{16, 4, 4, 0};
   localparam int PAT [4] = '{1, 0, 0, 1};

   logic clk = 0, rst_n = 1;
   logic start = 0, wdone = 0, valid = 0, cdone = 0, ready = 0;
   logic [15:0] din = '0;
   logic [3:0] we, cs, vo, ws, wd, ov;
   logic [3:0][7:0] ma;
   logic [3:0][15:0] mw, rd, dout;
   logic [15:0] refm [256];
   int epoch = 0;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   // Contents of a never-written memory word in the current epoch
   function automatic logic [15:0] initv(int a);
      return 16'(a * 40503 + epoch * 977 + 4660);
   endfunction

   for (genvar g = 0; g < 4; g++) begin : gen_dut
      logic [15:0] mem [256];
      int mep [256] = '{default: 0};
      com_stream_ctrl #(.ADDR_WIDTH(AWS[g]), .LOAD_BASE(LBS[g]), .DUMP_BASE(DBS[g]), .DUMP_LEN(DLS[g])) dut (
         .clk(clk), .rst_n(rst_n), .data_write_start(start), .data_write_done(wdone),
         .com_data_in(din), .com_valid_in(valid), .mem_addr(ma[g][AWS[g]-1:0]), .mem_wdata(mw[g]),
         .mem_we(we[g]), .mem_rdata(rd[g]), .cores_start(cs[g]), .cores_done(cdone),
         .com_data_out(dout[g]), .com_valid_out(vo[g]), .com_ready_in(ready),
         .output_write_start(ws[g]), .output_write_done(wd[g]), .load_overflow(ov[g]));
      if (AWS[g] < 8) begin : gen_pad
         assign ma[g][7:AWS[g]] = '0;
      end
      // Synchronous-read memory; words not written this epoch read as initv
      always @(posedge clk) begin
         if (we[g]) begin
            mem[ma[g]] <= mw[g];
            mep[ma[g]] <= epoch;
         end
         rd[g] <= (mep[ma[g]] == epoch) ? mem[ma[g]] : initv(int'(ma[g]));
      end
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic zero_chk(int k);
      chk("rst_we", we[k], 0);
      chk("rst_cores_start", cs[k], 0);
      chk("rst_valid", vo[k], 0);
      chk("rst_ows", ws[k], 0);
      chk("rst_owd", wd[k], 0);
      chk("rst_overflow", ov[k], 0);
      chk("rst_addr", ma[k], 0);
      chk("rst_wdata", mw[k], 0);
      chk("rst_dout", dout[k], 0);
   endtask

   task automatic do_reset(int k);
      @(negedge clk);
      rst_n = 0;
      start = 0;
      wdone = 0;
      valid = 0;
      cdone = 0;
      ready = 0;
      din = '0;
      epoch++;
      for (int a = 0; a < 256; a++) refm[a] = initv(a);
      #1 zero_chk(k);
      @(negedge clk);
      rst_n = 1;
   endtask

   // One session on DUT k: n words, ready mode (0 always, 1 pattern 1,0,0,1, 2 random),
   // cores_done rising on RUN cycle cdel (<=1: already high), dwl: done with last word,
   // rnd: random words/gaps else 5,7,9..., abort: reset after that many dump words
   task automatic session(int k, int n, int mode, int cdel, bit dwl, bit rnd, int abort);
      int lim = 1 << AWS[k];
      int lb = LBS[k], dl = DLS[k];
      int i = 0, ncs = 0, t = 0, got = 0, first = -1, rc;
      bit ovx = 0, stall = 0, fin = 0, rdy, xf, wr;
      logic [15:0] w, pd = '0;
      logic [15:0] q[$];
      cdone = cdel <= 1;
      start = 1;
      #1 chk("idle_ows", ws[k], 0);
      chk("idle_we", we[k], 0);
      @(negedge clk);
      start = 0;
      while (i < n) begin
         valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
         w = rnd ? 16'($urandom) : 16'(5 + 2 * i);
         din = w;
         wdone = dwl && valid && i == n - 1;
         wr = valid && lb + i < lim;
         #1 chk("load_ows", ws[k], 0);
         chk("overflow", ov[k], ovx);
         chk("we", we[k], wr);
         if (wr) begin
            chk("waddr", ma[k], lb + i);
            chk("wdata", mw[k], w);
            refm[lb + i] = w;
         end
         if (valid && !wr) ovx = 1;
         if (cs[k]) ncs++;
         if (valid) i++;
         @(negedge clk);
      end
      valid = 0;
      if (!(dwl && n > 0)) begin
         wdone = 1;
         #1 chk("load_end_we", we[k], 0);
         @(negedge clk);
      end
      wdone = 0;
      rc = cdel < 2 ? 2 : cdel;
      for (int j = 1; j <= rc; j++) begin
         cdone = j >= cdel;
         #1 chk("run_ows", ws[k], 0);
         chk("cores_start", cs[k], j == 1);
         if (j == 1) chk("run_overflow", ov[k], lb + n > lim);
         if (cs[k]) ncs++;
         @(negedge clk);
      end
      for (int j = 0; j < dl; j++) q.push_back(refm[(DBS[k] + j) % lim]);
      while (!fin) begin
         if (abort > 0 && got == abort) begin
            rst_n = 0;
            #1 zero_chk(k);
            return;
         end
         rdy = mode == 0 ? 1'b1 : mode == 1 ? PAT[t % 4] != 0 : 1'($urandom_range(1));
         ready = rdy;
         #1 chk("dump_ows", ws[k], 1);
         if (cs[k]) ncs++;
         if (stall) begin
            chk("hold_valid", vo[k], 1);
            chk("hold_data", dout[k], pd);
         end
         if (vo[k] && first < 0) begin
            first = t;
            chk("first_valid_by_2", t <= 2, 1);
         end
         if (mode == 0 && first >= 0 && got < dl) chk("contiguous", vo[k], 1);
         if (dl == 0) chk("empty_valid", vo[k], 0);
         xf = vo[k] && rdy;
         if (xf && got < dl) chk("dout", dout[k], q[got]);
         chk("owd", wd[k], dl == 0 || (xf && got == dl - 1));
         fin = wd[k] || dl == 0 || (xf && got >= dl - 1) || t > 200;
         if (xf) got++;
         stall = vo[k] && !rdy;
         pd = dout[k];
         t++;
         @(negedge clk);
      end
      chk("words", got, dl);
      chk("cores_start_pulses", ncs, 1);
      start = 1;
      valid = 1;
      repeat (3) begin
         #1 chk("done_ows", ws[k], 0);
         chk("done_we", we[k], 0);
         chk("done_valid", vo[k], 0);
         @(negedge clk);
      end
      start = 0;
      cdone = 0;
      @(negedge clk);
      #1 chk("idle_again_we", we[k], 0);
      chk("idle_again_ows", ws[k], 0);
      valid = 0;
      ready = 0;
      @(negedge clk);
   endtask

   initial begin
      int k;
      do_reset(0);
      session(0, 3, 0, 4, 0, 0, 0);
      do_reset(0);
      session(0, 6, 1, 2, 0, 1, 0);
      do_reset(1);
      session(1, 6, 0, 3, 0, 1, 0);
      do_reset(2);
      session(2, 5, 2, 2, 1, 1, 0);
      do_reset(3);
      session(3, 2, 0, 2, 0, 1, 0);
      do_reset(0);
      session(0, 4, 0, 1, 1, 0, 0);
      do_reset(0);
      session(0, 5, 0, 3, 0, 1, 3);
      @(negedge clk);
      rst_n = 1;
      session(0, 2, 1, 2, 0, 1, 0);
      for (int r = 0; r < 16; r++) begin
         k = $urandom_range(3);
         do_reset(k);
         session(k, $urandom_range(10), $urandom_range(2), $urandom_range(1, 5),
                 1'($urandom_range(1)), 1, 0);
      end
      do_reset(2);
      session(2, 3, 2, 3, 0, 1, 0);
      session(2, 7, 1, 1, 1, 1, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/com_stream_ctrl.md
COM_STREAM_CTRL -- requirements
Module: com_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, word width of the host stream and memory data.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, memory address width.
REQ-003 The block SHALL have parameter LOAD_BASE, default 0, first memory address written during load.
REQ-004 The block SHALL have parameter DUMP_BASE, default 0, first memory address read during dump.
REQ-005 The block SHALL have parameter DUMP_LEN, default 16, number of words dumped (0 to 2^ADDR_WIDTH).
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports data_write_start, input, 1, host load session request; and data_write_done, input, 1, host end of load.
REQ-009 The block SHALL have ports com_data_in, input, DATA_WIDTH, load word; and com_valid_in, input, 1, load word valid.
REQ-010 The block SHALL have ports mem_addr, output, ADDR_WIDTH; mem_wdata, output, DATA_WIDTH; mem_we, output, 1; mem_rdata, input, DATA_WIDTH; memory read data is valid one cycle after mem_addr.
REQ-011 The block SHALL have ports cores_start, output, 1, run pulse to cores; and cores_done, input, 1, cores finished (level).
REQ-012 The block SHALL have ports com_data_out, output, DATA_WIDTH; com_valid_out, output, 1; com_ready_in, input, 1, host accepts dump word.
REQ-013 The block SHALL have ports output_write_start, output, 1, dump phase active; output_write_done, output, 1, last dump word transferred; and load_overflow, output, 1, sticky overflow flag.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN, DUMP, DONE.
REQ-015 In IDLE, data_write_start=1 SHALL move the FSM to LOAD next cycle, with the load pointer set to LOAD_BASE.
REQ-016 In LOAD, each cycle with com_valid_in=1 SHALL drive mem_we=1, mem_addr=load pointer, mem_wdata=com_data_in combinationally in that cycle, then increment the pointer.
REQ-017 A valid word arriving when the load pointer has passed address 2^ADDR_WIDTH-1 SHALL NOT be written (mem_we=0), SHALL set load_overflow to 1 until reset, and the pointer SHALL NOT wrap.
REQ-018 data_write_done=1 in LOAD SHALL move the FSM to RUN; a valid word in the same cycle SHALL still be written.
REQ-019 cores_start SHALL be 1 for exactly the first RUN cycle; cores_done SHALL be ignored in that cycle and sampled from the second RUN cycle on, so the FSM moves to DUMP the cycle after cores_done=1 is sampled.
REQ-020 output_write_start SHALL be 1 in every DUMP cycle and 0 in every other state.
REQ-021 In DUMP the block SHALL read addresses DUMP_BASE to DUMP_BASE+DUMP_LEN-1 in order, wrapping modulo 2^ADDR_WIDTH, and present each word on com_data_out with com_valid_out=1.
REQ-022 The first com_valid_out SHALL assert no later than the 2nd cycle after DUMP entry; with com_ready_in held at 1, one word SHALL transfer per cycle with no gaps.
REQ-023 A transfer SHALL occur only when com_valid_out=1 and com_ready_in=1; while com_valid_out=1 and com_ready_in=0, com_data_out SHALL hold stable, and no word SHALL be dropped or duplicated (skid or hold register required).
REQ-024 output_write_done SHALL be 1 for exactly the cycle of the last word's transfer, and the FSM SHALL move to DONE on the next cycle.
REQ-025 When DUMP_LEN=0, DUMP SHALL last one cycle with output_write_done=1 and com_valid_out=0.
REQ-026 mem_we SHALL be 0 outside LOAD.
REQ-027 DONE SHALL return to IDLE once data_write_start=0; a new session SHALL NOT start until data_write_start is seen low and then high again.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and at any state including mid-load or mid-dump, force IDLE and drive mem_we, cores_start, com_valid_out, output_write_start, output_write_done and load_overflow to 0, and mem_addr, mem_wdata and com_data_out to 0, with pointers cleared.
REQ-029 After rst_n deasserts, the first state change SHALL occur on the first rising clk edge.

Verification
REQ-030 The bench SHALL cover a basic session: defaults, load 5,7,9 at addresses 0..2, cores_done 3 cycles after the start pulse, ready=1 -> 16 words out contiguously, output_write_done on the 16th, exactly one cores_start pulse.
REQ-031 The bench SHALL cover backpressure: toggle com_ready_in 1,0,0,1 every cycle during dump -> the output sequence equals memory contents with none dropped or duplicated and data stable while stalled.
REQ-032 The bench SHALL cover overflow: ADDR_WIDTH=2, load 6 words -> 4 written, load_overflow=1, the 5th and 6th have mem_we=0.
REQ-033 The bench SHALL cover wrap-around and the empty dump: ADDR_WIDTH=3, DUMP_BASE=6, DUMP_LEN=4 -> reads addresses 6,7,0,1; DUMP_LEN=0 -> a single output_write_done pulse, no valid.
REQ-034 The bench SHALL cover simultaneous events: data_write_done and com_valid_in in the same cycle -> the word is written and RUN entered; cores_done already high -> DUMP entered 2 cycles after RUN entry.
REQ-035 The bench SHALL cover reset mid-dump: rst_n=0 after 3 words -> all outputs 0 immediately, then a new session works from IDLE.
